seg_to_bin: RTL
===============

SEG_TO_BIN -- requirements
Module: seg_to_bin

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive identical registered samples (legal range 2..15) that qualify a pattern.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port seg_in, input, 14, active-low segments {a1..g1, a2..g2}, MSB first; digit 1 is sign, digit 2 is magnitude.
REQ-005 SHALL have port out_ready, input, 1, consumer accepts value.
REQ-006 SHALL have port value, output, 4, decoded two's-complement result.
REQ-007 SHALL have port out_valid, output, 1, value is valid and held.
REQ-008 SHALL have port err, output, 1, one-cycle pulse for a qualified illegal pattern.
REQ-009 SHALL have port err_cnt, output, 8, saturating count of err pulses.

Function
REQ-010 SHALL register seg_in into seg_q every cycle; the FSM uses only seg_q.
REQ-011 Sign digit SHALL be legal only as 1111111 (positive) or 1111110 (minus, g lit).
REQ-012 Magnitude digit SHALL be legal only as: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000.
REQ-013 Positive sign with m 0..7 SHALL give value=m; minus sign with m 1..8 SHALL give value=(16-m) mod 16.
REQ-014 Illegal: any other digit code, positive 8, minus 0.
REQ-015 FSM states SHALL be IDLE, SETTLE, PRESENT.
REQ-016 IDLE: if seg_q != last_pat, go to SETTLE with cand=seg_q and cnt=1; otherwise remain.
REQ-017 SETTLE: if seg_q == cand, cnt increments; if seg_q != cand, cand=seg_q and cnt=1 (restart), staying in SETTLE.
REQ-018 SETTLE, on the edge where cnt reaches STABLE_CYCLES, a legal cand SHALL go to PRESENT with value loaded, out_valid=1, last_pat=cand.
REQ-019 SETTLE, in the same case with an illegal cand, SHALL pulse err for one cycle, increment err_cnt (saturating at 255), set last_pat=cand, and go to IDLE; out_valid stays 0.
REQ-020 Latency: a pattern held from the rising edge that first registers it SHALL raise out_valid after STABLE_CYCLES further edges.
REQ-021 PRESENT: value and out_valid SHALL hold until out_valid && out_ready; on that edge out_valid falls and the state returns to IDLE.
REQ-022 seg_q changes during PRESENT SHALL be ignored; they are detected in IDLE after the handshake.
REQ-023 A re-qualified pattern equal to last_pat SHALL NOT produce a second out_valid or err.
REQ-024 A seg_q change on the same edge cnt would reach STABLE_CYCLES SHALL restart per REQ-017 and produce no output.

Reset
REQ-025 While rst_n=0, outputs SHALL be value=0, out_valid=0, err=0, err_cnt=0 immediately, independent of clk.
REQ-026 Reset SHALL set state=IDLE, cnt=0, cand=seg_q=last_pat=14'h3FFF (all off), so an all-off input after reset raises no err.
REQ-027 Reset mid-SETTLE or mid-PRESENT SHALL discard the pending pattern; after release it is re-qualified from scratch.

Structure
REQ-028 A shared package seg_pkg SHALL hold the FSM state enum, SEG_BLANK, SEG_MINUS, and the nine magnitude digit constants.
REQ-029 One combinational sub-module seg_digit_lut SHALL map a 7-bit digit to {legal, magnitude[3:0]}; sign check and value arithmetic stay in seg_to_bin.

Verification
REQ-030 After reset, hold seg_in=14'b1111111_0000110 with out_ready=1 -> out_valid for one cycle with value=4'h3, err=0.
REQ-031 Hold 14'b1111110_0000000 with out_ready=0 for 10 cycles -> value=4'h8 and out_valid held all 10 cycles; then out_ready=1 -> out_valid low the next cycle.
REQ-032 Toggle between the 2 and 5 patterns every 2 cycles for 12 cycles, then hold 5 (14'b1111111_0100100) -> exactly one out_valid, value=4'h5.
REQ-033 Hold 14'b1111110_0000001 (minus zero) -> one err pulse, err_cnt=1, no out_valid; keep holding -> no further err.
REQ-034 Assert rst_n=0 two cycles into SETTLE -> outputs zero at once; after release, the same pattern decodes normally STABLE_CYCLES edges later.
REQ-035 After a completed handshake for 14'b1111110_1001111, keep the input unchanged -> no second out_valid; then change to 1111111_0001111 -> value=4'h7.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared FSM state type and seven-segment code constants
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  // Active-low segment codes, bit 6 = segment a, bit 0 = segment g
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  localparam logic [6:0] DIG_0 = 7'b0000001;
  localparam logic [6:0] DIG_1 = 7'b1001111;
  localparam logic [6:0] DIG_2 = 7'b0010010;
  localparam logic [6:0] DIG_3 = 7'b0000110;
  localparam logic [6:0] DIG_4 = 7'b1001100;
  localparam logic [6:0] DIG_5 = 7'b0100100;
  localparam logic [6:0] DIG_6 = 7'b0100000;
  localparam logic [6:0] DIG_7 = 7'b0001111;
  localparam logic [6:0] DIG_8 = 7'b0000000;

  localparam logic [13:0] SEG_ALL_OFF = 14'h3FFF;

endpackage

// File: rtl/seg_digit_lut.sv
// rtl/seg_digit_lut.sv - maps one magnitude digit code to {legal, magnitude}
module seg_digit_lut
  import seg_pkg::*;
(
  input  logic [6:0] digit,
  output logic       legal,
  output logic [3:0] mag
);

  always_comb begin
    legal = 1'b1;
    mag   = 4'd0;
    case (digit)
      DIG_0:   mag = 4'd0;
      DIG_1:   mag = 4'd1;
      DIG_2:   mag = 4'd2;
      DIG_3:   mag = 4'd3;
      DIG_4:   mag = 4'd4;
      DIG_5:   mag = 4'd5;
      DIG_6:   mag = 4'd6;
      DIG_7:   mag = 4'd7;
      DIG_8:   mag = 4'd8;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_to_bin.sv
// rtl/seg_to_bin.sv - debounced two-digit seven-segment reader producing a
// signed 4-bit value with valid/ready handshake and illegal-pattern counting
module seg_to_bin
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] seg_in,
  input  logic        out_ready,
  output logic [3:0]  value,
  output logic        out_valid,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [13:0] seg_q, seg_d;
  logic [13:0] cand_q, cand_d;
  logic [13:0] last_pat_q, last_pat_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  value_q, value_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic        mag_legal;
  logic [3:0]  mag;
  logic        sign_pos;
  logic        sign_neg;
  logic        cand_legal;
  logic [3:0]  cand_value;

  seg_digit_lut u_digit_lut (
    .digit (cand_q[6:0]),
    .legal (mag_legal),
    .mag   (mag)
  );

  // Positive zero is legal, minus zero is not; +8 does not fit in 4-bit two's complement
  assign sign_pos   = (cand_q[13:7] == SEG_BLANK);
  assign sign_neg   = (cand_q[13:7] == SEG_MINUS);
  assign cand_legal = mag_legal && ((sign_pos && (mag != 4'd8)) ||
                                    (sign_neg && (mag != 4'd0)));
  assign cand_value = sign_neg ? (4'd0 - mag) : mag;

  always_comb begin
    seg_d       = seg_in;
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    last_pat_d  = last_pat_q;
    value_d     = value_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (seg_q != last_pat_q) begin
          state_d = ST_SETTLE;
          cand_d  = seg_q;
          cnt_d   = 4'd1;
        end
      end

      ST_SETTLE: begin
        if (seg_q != cand_q) begin
          cand_d = seg_q;
          cnt_d  = 4'd1;
        end else if (cnt_q == CNT_LAST) begin
          // Remember the pattern either way so a steady input is reported only once
          last_pat_d = cand_q;
          cnt_d      = 4'd0;
          if (cand_legal) begin
            state_d     = ST_PRESENT;
            value_d     = cand_value;
            out_valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_d = err_cnt_q + 8'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_PRESENT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seg_q       <= SEG_ALL_OFF;
      cand_q      <= SEG_ALL_OFF;
      last_pat_q  <= SEG_ALL_OFF;
      cnt_q       <= 4'd0;
      value_q     <= 4'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      cand_q      <= cand_d;
      last_pat_q  <= last_pat_d;
      cnt_q       <= cnt_d;
      value_q     <= value_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign value     = value_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule
